// File: rtl/cnn_pkg.sv
// Shared geometry, state encoding and window layout helper for the CNN frame feeder.
package cnn_pkg;

  localparam int unsigned IMG_W     = 28;
  localparam int unsigned WIN       = 5;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned CONV_W    = IMG_W - WIN + 1;
  localparam int unsigned NUM_PIX   = IMG_W * IMG_W;
  localparam int unsigned NUM_POS   = CONV_W * CONV_W;
  localparam int unsigned WIN_BITS  = WIN * WIN * PIX_W;
  localparam int unsigned POS_W     = $clog2(CONV_W);
  localparam int unsigned PIX_CNT_W = $clog2(NUM_PIX);
  localparam int unsigned POS_CNT_W = $clog2(NUM_POS);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_KICK,
    ST_SCAN,
    ST_WAIT,
    ST_RESULT
  } state_e;

  // Bit offset of window pixel (i,j) inside the flattened IMGIN bus.
  function automatic int unsigned win_off(input int unsigned i, input int unsigned j);
    return (i * WIN + j) * PIX_W;
  endfunction

endpackage

// File: rtl/cnn_window_mux.sv
// Combinational 5x5 window extractor from the buffered 28x28 image.
module cnn_window_mux
  import cnn_pkg::*;
(
  input  logic [PIX_W-1:0]    pix_buf [NUM_PIX],
  input  logic [POS_W-1:0]    org_r,
  input  logic [POS_W-1:0]    org_c,
  output logic [WIN_BITS-1:0] window
);

  // Gather pixel (org_r+i, org_c+j) into slot (i*WIN+j).
  always_comb begin
    window = '0;
    for (int unsigned i = 0; i < WIN; i++) begin
      for (int unsigned j = 0; j < WIN; j++) begin
        window[8'(win_off(i, j)) +: PIX_W] =
          pix_buf[PIX_CNT_W'((32'(org_r) + i) * IMG_W + 32'(org_c) + j)];
      end
    end
  end

endmodule

// File: rtl/cnn_frame_feeder.sv
// Buffers one raster image, scans it into the CNN core window interface and
// returns the core's class index on a ready/valid result port.
module cnn_frame_feeder
  import cnn_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                PIX_VALID,
  input  logic [PIX_W-1:0]    PIX_DATA,
  output logic                PIX_READY,
  output logic                START,
  output logic [POS_W-1:0]    X,
  output logic [POS_W-1:0]    Y,
  output logic [WIN_BITS-1:0] IMGIN,
  input  logic                DONE_IN,
  input  logic [3:0]          OUT_IN,
  input  logic                RES_READY,
  output logic                RES_VALID,
  output logic [3:0]          RES_CLASS,
  output logic                RES_ERR,
  output logic                BUSY
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e               state;
  logic [PIX_CNT_W-1:0] pix_cnt;
  logic [POS_CNT_W-1:0] pos_cnt;
  logic [POS_W-1:0]     cur_r, cur_c;
  logic [POS_W-1:0]     win_r, win_c;
  logic [TW-1:0]        wait_cnt;
  logic                 res_valid_q;
  logic [3:0]           res_class_q;
  logic                 res_err_q;
  logic [PIX_W-1:0]     pix_buf [NUM_PIX];
  logic [WIN_BITS-1:0]  win_data;
  logic                 scan_last;

  assign scan_last = (pos_cnt == POS_CNT_W'(NUM_POS - 1));

  // Image storage; contents are don't-care after reset so no reset branch.
  always_ff @(posedge CLK) begin
    if (state == ST_LOAD && PIX_VALID)
      pix_buf[pix_cnt] <= PIX_DATA;
  end

  // Main sequencer: load, kick, scan, wait for DONE, hold the result.
  // win_r/win_c run one position ahead of cur_r/cur_c; they stop at (23,23)
  // on the last step so the mux never indexes past the buffer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= ST_LOAD;
      pix_cnt     <= '0;
      pos_cnt     <= '0;
      cur_r       <= '0;
      cur_c       <= '0;
      win_r       <= '0;
      win_c       <= '0;
      wait_cnt    <= '0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          win_r <= '0;
          win_c <= '0;
          if (PIX_VALID) begin
            if (pix_cnt == PIX_CNT_W'(NUM_PIX - 1)) begin
              pix_cnt <= '0;
              state   <= ST_KICK;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        ST_KICK: begin
          pos_cnt <= '0;
          cur_r   <= '0;
          cur_c   <= '0;
          win_r   <= '0;
          win_c   <= POS_W'(1);
          state   <= ST_SCAN;
        end
        ST_SCAN: begin
          if (scan_last) begin
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end else begin
            pos_cnt <= pos_cnt + 1'b1;
            if (cur_c == POS_W'(CONV_W - 1)) begin
              cur_c <= '0;
              cur_r <= cur_r + 1'b1;
            end else begin
              cur_c <= cur_c + 1'b1;
            end
            if (pos_cnt != POS_CNT_W'(NUM_POS - 2)) begin
              if (win_c == POS_W'(CONV_W - 1)) begin
                win_c <= '0;
                win_r <= win_r + 1'b1;
              end else begin
                win_c <= win_c + 1'b1;
              end
            end
          end
        end
        ST_WAIT: begin
          if (DONE_IN) begin
            res_valid_q <= 1'b1;
            res_class_q <= OUT_IN;
            res_err_q   <= 1'b0;
            state       <= ST_RESULT;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            res_valid_q <= 1'b1;
            res_class_q <= 4'hF;
            res_err_q   <= 1'b1;
            state       <= ST_RESULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESULT: begin
          if (RES_READY) begin
            res_valid_q <= 1'b0;
            res_class_q <= '0;
            res_err_q   <= 1'b0;
            state       <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  cnn_window_mux u_window_mux (
    .pix_buf (pix_buf),
    .org_r   (win_r),
    .org_c   (win_c),
    .window  (win_data)
  );

  // Core-facing and handshake outputs decoded from state and counters.
  always_comb begin
    PIX_READY = (state == ST_LOAD);
    BUSY      = (state != ST_LOAD);
    START     = (state == ST_KICK);
    X         = (state == ST_SCAN) ? cur_r : '0;
    Y         = (state == ST_SCAN) ? cur_c : '0;
    IMGIN     = ((state == ST_KICK) || (state == ST_SCAN && !scan_last)) ? win_data : '0;
    RES_VALID = res_valid_q;
    RES_CLASS = res_class_q;
    RES_ERR   = res_err_q;
  end

endmodule

// File: tb/tb_cnn_frame_feeder.sv
// Directed/randomized self-checking bench for cnn_frame_feeder.
module tb_cnn_frame_feeder;

  localparam int unsigned TMO = 32;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         PIX_VALID;
  logic [7:0]   PIX_DATA;
  logic         PIX_READY;
  logic         START;
  logic [4:0]   X, Y;
  logic [199:0] IMGIN;
  logic         DONE_IN;
  logic [3:0]   OUT_IN;
  logic         RES_READY;
  logic         RES_VALID;
  logic [3:0]   RES_CLASS;
  logic         RES_ERR;
  logic         BUSY;

  logic [7:0]   img [784];
  int           checks = 0;
  int           failures = 0;
  logic [3:0]   cls;

  cnn_frame_feeder #(.TIMEOUT(TMO)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .PIX_VALID (PIX_VALID),
    .PIX_DATA  (PIX_DATA),
    .PIX_READY (PIX_READY),
    .START     (START),
    .X         (X),
    .Y         (Y),
    .IMGIN     (IMGIN),
    .DONE_IN   (DONE_IN),
    .OUT_IN    (OUT_IN),
    .RES_READY (RES_READY),
    .RES_VALID (RES_VALID),
    .RES_CLASS (RES_CLASS),
    .RES_ERR   (RES_ERR),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Window at conv position (r,c) built straight from the image array.
  function automatic logic [199:0] exp_win(input int r, input int c);
    logic [199:0] w;
    w = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        w[8'((i * 5 + j) * 8) +: 8] = img[10'((r + i) * 28 + c + j)];
    return w;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pix_ready"}, 200'(PIX_READY), 200'(1));
    chk({tag, "_start"},     200'(START),     200'(0));
    chk({tag, "_xy"},        200'({X, Y}),    200'(0));
    chk({tag, "_imgin"},     IMGIN,           200'(0));
    chk({tag, "_res"},       200'({RES_VALID, RES_CLASS, RES_ERR}), 200'(0));
    chk({tag, "_busy"},      200'(BUSY),      200'(0));
  endtask

  // Stream img[] in raster order; gaps gives ~50% PIX_VALID duty.
  task automatic load_image(input bit gaps);
    int  n = 0;
    int  guard = 0;
    bit  pv;
    while (n < 784 && guard < 5000) begin
      pv = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
      PIX_VALID = pv;
      PIX_DATA  = pv ? img[n] : 8'($urandom);
      if (pv && PIX_READY) n++;
      tick();
      guard++;
    end
    PIX_VALID = 1'b0;
    chk("load_count", 200'(n), 200'(784));
  endtask

  task automatic check_kick();
    chk("kick_start", 200'(START),     200'(1));
    chk("kick_xy",    200'({X, Y}),    200'(0));
    chk("kick_imgin", IMGIN,           exp_win(0, 0));
    chk("kick_pixrdy",200'(PIX_READY), 200'(0));
    chk("kick_busy",  200'(BUSY),      200'(1));
  endtask

  // Walk T1..T576 then land on T577 (first WAIT cycle).
  task automatic scan_trace(input int spurious_k);
    for (int k = 0; k < 576; k++) begin
      tick();
      DONE_IN = (k == spurious_k);
      OUT_IN  = (k == spurious_k) ? 4'h2 : 4'h0;
      chk("scan_xy",    200'({X, Y}), 200'({5'(k / 24), 5'(k % 24)}));
      chk("scan_imgin", IMGIN, (k < 575) ? exp_win((k + 1) / 24, (k + 1) % 24) : 200'(0));
      chk("scan_start", 200'(START), 200'(0));
      if (k == 0) chk("scan0_byte0", 200'(IMGIN[7:0]), 200'(img[1]));
    end
    tick();
    DONE_IN = 1'b0;
    OUT_IN  = 4'h0;
    chk("wait_xy",    200'({X, Y, START}), 200'(0));
    chk("wait_imgin", IMGIN, 200'(0));
    chk("wait_busy",  200'({BUSY, RES_VALID}), 200'(2'b10));
  endtask

  // Stub core: DONE at T587 with class c, result expected at T588.
  task automatic done_at_587(input logic [3:0] c);
    repeat (10) begin
      tick();
      chk("pre_done_valid", 200'(RES_VALID), 200'(0));
    end
    DONE_IN = 1'b1;
    OUT_IN  = c;
    tick();
    DONE_IN = 1'b0;
    OUT_IN  = ~c;
    chk("res_valid", 200'(RES_VALID), 200'(1));
    chk("res_class", 200'(RES_CLASS), 200'(c));
    chk("res_err",   200'(RES_ERR),   200'(0));
  endtask

  task automatic accept_result();
    RES_READY = 1'b1;
    PIX_VALID = 1'b0;
    tick();
    RES_READY = 1'b0;
    chk("post_res_pixrdy", 200'(PIX_READY), 200'(1));
    chk("post_res_valid",  200'(RES_VALID), 200'(0));
    chk("post_res_busy",   200'(BUSY),      200'(0));
  endtask

  initial begin
    nRST = 1'b0; PIX_VALID = 1'b0; PIX_DATA = '0;
    DONE_IN = 1'b0; OUT_IN = '0; RES_READY = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    nRST = 1'b1;
    tick();

    // Ramp image, class 7 from a correctly timed core stub.
    for (int n = 0; n < 784; n++) img[n] = 8'(n % 256);
    load_image(1'b0);
    check_kick();
    chk("kick_b0",  200'(IMGIN[7:0]),     200'(0));
    chk("kick_b4",  200'(IMGIN[39:32]),   200'(4));
    chk("kick_b5",  200'(IMGIN[47:40]),   200'(28));
    chk("kick_b24", 200'(IMGIN[199:192]), 200'(116));
    scan_trace(-1);
    done_at_587(4'd7);
    accept_result();

    // Random image with valid gaps, DONE glitch during SCAN, held result.
    for (int n = 0; n < 784; n++) img[n] = 8'($urandom);
    load_image(1'b1);
    check_kick();
    scan_trace(100);
    cls = 4'($urandom_range(0, 14));
    done_at_587(cls);
    for (int t = 0; t < 20; t++) begin
      PIX_VALID = 1'b1;
      PIX_DATA  = 8'($urandom);
      tick();
      chk("hold_valid",  200'(RES_VALID), 200'(1));
      chk("hold_class",  200'({RES_CLASS, RES_ERR}), 200'({cls, 1'b0}));
      chk("hold_pixrdy", 200'(PIX_READY), 200'(0));
    end
    accept_result();

    // Core never answers: timeout result TIMEOUT cycles after WAIT entry.
    for (int n = 0; n < 784; n++) img[n] = 8'($urandom);
    load_image(1'b0);
    check_kick();
    scan_trace(-1);
    repeat (TMO - 1) begin
      tick();
      chk("tmo_pending", 200'(RES_VALID), 200'(0));
    end
    tick();
    chk("tmo_valid", 200'(RES_VALID), 200'(1));
    chk("tmo_class", 200'(RES_CLASS), 200'(4'hF));
    chk("tmo_err",   200'(RES_ERR),   200'(1));
    DONE_IN = 1'b1;
    OUT_IN  = 4'h3;
    tick();
    DONE_IN = 1'b0;
    chk("tmo_late_done", 200'({RES_VALID, RES_CLASS, RES_ERR}), 200'({1'b1, 4'hF, 1'b1}));
    accept_result();

    // Reset mid-scan at (10,5), then a clean frame.
    for (int n = 0; n < 784; n++) img[n] = 8'($urandom);
    load_image(1'b1);
    check_kick();
    for (int k = 0; k <= 245; k++) tick();
    chk("pre_rst_xy", 200'({X, Y}), 200'({5'd10, 5'd5}));
    nRST = 1'b0;
    #1;
    chk_reset_outputs("midscan_rst");
    tick();
    tick();
    nRST = 1'b1;
    tick();
    chk_reset_outputs("after_rst");
    for (int n = 0; n < 784; n++) img[n] = 8'($urandom);
    load_image(1'b1);
    check_kick();
    scan_trace(-1);
    cls = 4'($urandom_range(0, 14));
    done_at_587(cls);
    accept_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
